// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter and sequencer in front of a single-port Mem.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the D port has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_sel,
  output logic              mem_ld,
  output logic              mem_str,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  // Handshake: a port raises req and holds it (with stable address/data) until
  // its one-cycle ack; req still high during the ack cycle is a fresh request.
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t state, next_state;
  logic   lat_d;
  logic   lat_we;
  logic   any_req;
  logic   grant_d;

  assign any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  // last_d = 1 means D was granted most recently; reset value lets I win the first tie.
  logic last_d;

  assign grant_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      last_d <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_d <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mem_sel    = 1'b0;
    mem_ld     = 1'b0;
    mem_str    = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) next_state = ACCESS;
      end
      ACCESS: begin
        mem_sel    = 1'b1;
        mem_ld     = ~lat_we;
        mem_str    = lat_we;
        next_state = WAIT;
      end
      WAIT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latched request, Mem address/data registers, read data capture and acks.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      lat_d    <= 1'b0;
      lat_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (state == IDLE && any_req) begin
        lat_d    <= grant_d;
        lat_we   <= grant_d & d_we;
        mem_addr <= grant_d ? d_addr : i_addr;
        if (grant_d) mem_din <= d_wdata;
      end
      if (state == WAIT) begin
        if (lat_d) begin
          d_ack <= 1'b1;
          if (!lat_we) d_rdata <= mem_dout;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= mem_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural Mem model, table of D-port vectors,
// and hand-written sequences for ties, reset mid-access and back-to-back I reads.
module tb_mem_port_arbiter;

  logic        clk;
  logic        clr;
  logic        i_req;
  logic [9:0]  i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_sel;
  logic        mem_ld;
  logic        mem_str;
  logic [31:0] mem_dout;
  logic        busy;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .clr(clr),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_sel(mem_sel),
    .mem_ld(mem_ld), .mem_str(mem_str), .mem_dout(mem_dout), .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Single-port Mem model: registered read, write on str.
  logic [31:0] mem_arr [1024];
  always @(posedge clk) begin
    if (mem_sel) begin
      if (mem_str) mem_arr[mem_addr] <= mem_din;
      if (mem_ld)  mem_dout <= mem_arr[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Driver: one D access starting at a negedge, ending at the ack negedge.
  int sel_cyc, str_cyc, ld_cyc, iack_seen;
  logic [9:0]  seen_addr;
  logic [31:0] seen_din;

  task automatic d_access(input logic we, input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    lat = 0; sel_cyc = 0; str_cyc = 0; ld_cyc = 0; iack_seen = 0;
    seen_addr = '0; seen_din = '0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (mem_sel) begin
        sel_cyc++;
        seen_addr = mem_addr;
        seen_din  = mem_din;
      end
      if (mem_str) str_cyc++;
      if (mem_ld)  ld_cyc++;
      if (i_ack)   iack_seen++;
      if (d_ack) break;
    end
    rd = d_rdata;
    d_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rd;
    logic [31:0] exp;
    int lat;
    int grants [4];
    int n_grant, n_i, n_d, cyc, ack1, ack2, dack_cnt, unstable;
    logic [31:0] i_exp;

    checks = 0; failures = 0;
    clr = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state_busy", 32'(busy), 32'd0);
    check("rst_mem_sel", 32'({mem_sel, mem_ld, mem_str}), 32'd0);
    check("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    clr = 1'b1;

    // D-port vector table; exp_rdata is d_rdata after the ack (held on writes).
    vecs[0] = '{1'b1, 10'h005, 32'h0000_00A5, 32'h0000_0000};
    vecs[1] = '{1'b0, 10'h005, 32'h0000_0000, 32'h0000_00A5};
    vecs[2] = '{1'b1, 10'h3FF, 32'hDEAD_BEEF, 32'h0000_00A5};
    vecs[3] = '{1'b1, 10'h000, 32'h1234_5678, 32'h0000_00A5};
    vecs[4] = '{1'b0, 10'h3FF, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 10'h000, 32'h0000_0000, 32'h1234_5678};
    vecs[6] = '{1'b1, 10'h005, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[7] = '{1'b0, 10'h005, 32'h0000_0000, 32'hFFFF_FFFF};

    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(vecs[v].exp_rdata);
      d_access(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, lat);
      exp = exp_q.pop_front();
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd3);
      check($sformatf("v%0d_sel_cycles", v), 32'(sel_cyc), 32'd1);
      check($sformatf("v%0d_str_cycles", v), 32'(str_cyc), 32'(vecs[v].we));
      check($sformatf("v%0d_ld_cycles", v), 32'(ld_cyc), 32'(!vecs[v].we));
      check($sformatf("v%0d_mem_addr", v), 32'(seen_addr), 32'(vecs[v].addr));
      if (vecs[v].we) check($sformatf("v%0d_mem_din", v), seen_din, vecs[v].wdata);
      check($sformatf("v%0d_d_rdata", v), rd, exp);
      check($sformatf("v%0d_no_i_ack", v), 32'(iack_seen), 32'd0);
    end

    // mem_addr holds outside ACCESS, strobes low
    @(negedge clk);
    check("idle_mem_addr_hold", 32'(mem_addr), 32'h005);
    check("idle_strobes", 32'({mem_sel, mem_ld, mem_str}), 32'd0);

    // Preload for tie test (last grant is D)
    d_access(1'b1, 10'h010, 32'h1111_0000, rd, lat);
    d_access(1'b1, 10'h020, 32'h2222_0000, rd, lat);

    // Tie: I read and D read held for 4 accesses
    i_req = 1'b1; i_addr = 10'h010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
    n_grant = 0; n_i = 0; n_d = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_sel && n_grant < 4) begin
        grants[n_grant] = (mem_addr == 10'h020) ? 1 : 0;
        n_grant++;
      end
      if (i_ack) begin
        n_i++;
        check("tie_i_rdata", i_rdata, 32'h1111_0000);
      end
      if (d_ack) begin
        n_d++;
        check("tie_d_rdata", d_rdata, 32'h2222_0000);
      end
      if (n_i + n_d == 4) break;
    end
    i_req = 1'b0; d_req = 1'b0;
    check("tie_grant_count", 32'(n_grant), 32'd4);
`ifdef MEM_ARB_RR_EN
    for (int g = 0; g < 4; g++) check($sformatf("tie_rr_grant%0d", g), 32'(grants[g]), 32'(g % 2));
    check("tie_rr_i_acks", 32'(n_i), 32'd2);
`else
    for (int g = 0; g < 4; g++) check($sformatf("tie_fixed_grant%0d", g), 32'(grants[g]), 32'd1);
    check("tie_fixed_i_acks", 32'(n_i), 32'd0);
`endif
    @(negedge clk);

    // Reset pulsed during ACCESS of a D write
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h030; d_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    check("rstacc_str_before", 32'(mem_str), 32'd1);
    #2 clr = 1'b0;
    #1;
    check("rstacc_strobes", 32'({mem_sel, mem_ld, mem_str}), 32'd0);
    check("rstacc_busy", 32'(busy), 32'd0);
    check("rstacc_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    dack_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_ack) dack_cnt++;
    end
    check("rstacc_no_d_ack", 32'(dack_cnt), 32'd0);
    d_access(1'b0, 10'h005, 32'h0, rd, lat);
    check("rstacc_next_latency", 32'(lat), 32'd3);
    check("rstacc_next_rdata", rd, 32'hFFFF_FFFF);

    // I read held through its ack: back-to-back accesses
    i_req = 1'b1; i_addr = 10'h010;
    cyc = 0; ack1 = -1; ack2 = -1; unstable = 0; dack_cnt = 0;
    i_exp = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cyc++;
      if (d_ack) dack_cnt++;
      if (i_ack) begin
        if (ack1 < 0) begin
          ack1 = cyc;
          check("hold_ack1_rdata", i_rdata, 32'h1111_0000);
          i_exp = 32'h1111_0000;
          i_addr = 10'h020;
        end else begin
          ack2 = cyc;
          check("hold_ack2_rdata", i_rdata, 32'h2222_0000);
          break;
        end
      end else if (i_rdata !== i_exp) begin
        unstable++;
      end
    end
    i_req = 1'b0;
    check("hold_ack1_latency", 32'(ack1), 32'd3);
    check("hold_ack_spacing", 32'(ack2 - ack1), 32'd3);
    check("hold_i_rdata_stable", 32'(unstable), 32'd0);
    check("hold_no_d_ack", 32'(dack_cnt), 32'd0);

    repeat (2) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
